// File: rtl/subservient_dbg_pkg.sv
// Shared constants and state encoding for the subservient debug bridge.
package subservient_dbg_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] OP_DBG_ON  = 8'h03;
  localparam logic [7:0] OP_DBG_OFF = 8'h04;

  localparam logic [7:0] RSP_OK  = 8'hA5;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/subservient_dbg_bridge.sv
// Byte-stream command decoder driving a single-word Wishbone debug initiator
// and the SoC debug-mode line; responses are serialised onto a byte stream.
module subservient_dbg_bridge
  import subservient_dbg_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ready,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic [31:0] i_wb_dbg_rdt,
  input  logic        i_wb_dbg_ack,
  output logic        o_debug_mode
);

  localparam int             TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TIMER_ONE  = TW'(1);

  state_t        state, state_d;
  logic [31:0]   adr, adr_d;
  logic [31:0]   dat, dat_d;
  logic [1:0]    cnt, cnt_d;
  logic [2:0]    rsp_cnt, rsp_cnt_d;
  logic [TW-1:0] timer, timer_d;
  logic          is_write, is_write_d;
  logic          dbg, dbg_d;
  logic          rx_fire, tx_fire;

  // Ready is masked by reset so nothing is accepted while reset is held.
  assign o_rx_ready = !i_rst &&
                      (state == ST_IDLE || state == ST_ADDR || state == ST_DATA);
  assign rx_fire    = i_rx_valid && o_rx_ready;
  assign o_tx_valid = (state == ST_RESP);
  assign tx_fire    = o_tx_valid && i_tx_ready;
  assign o_tx_data  = o_tx_valid ? dat[7:0] : 8'h00;

  assign o_wb_dbg_stb = (state == ST_BUS);
  assign o_wb_dbg_adr = adr;
  assign o_wb_dbg_dat = dat;
  assign o_wb_dbg_we  = o_wb_dbg_stb && is_write;
  assign o_wb_dbg_sel = o_wb_dbg_stb ? 4'hf : 4'h0;
  assign o_debug_mode = dbg;

  always_comb begin
    // NOTE: every next-value is defaulted to its current value first, so no
    // branch can leave one unassigned and infer a latch.
    state_d    = state;
    adr_d      = adr;
    dat_d      = dat;
    cnt_d      = cnt;
    rsp_cnt_d  = rsp_cnt;
    timer_d    = timer;
    is_write_d = is_write;
    dbg_d      = dbg;

    unique case (state)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d = 2'd0;
          if (i_rx_data == OP_WRITE || i_rx_data == OP_READ) begin
            is_write_d = (i_rx_data == OP_WRITE);
            state_d    = ST_ADDR;
          end else begin
            state_d   = ST_RESP;
            rsp_cnt_d = 3'd1;
            dat_d     = {24'h0, RSP_OK};
            if (i_rx_data == OP_DBG_ON)       dbg_d = 1'b1;
            else if (i_rx_data == OP_DBG_OFF) dbg_d = 1'b0;
            else                              dat_d = {24'h0, RSP_ERR};
          end
        end
      end

      ST_ADDR: begin
        if (rx_fire) begin
          // Little-endian: each new byte enters at the top and shifts down.
          adr_d = {i_rx_data, adr[31:8]};
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (is_write) begin
              state_d = ST_DATA;
            end else if (dbg) begin
              state_d = ST_BUS;
              timer_d = '0;
            end else begin
              state_d   = ST_RESP;
              rsp_cnt_d = 3'd1;
              dat_d     = {24'h0, RSP_ERR};
            end
          end
        end
      end

      ST_DATA: begin
        if (rx_fire) begin
          dat_d = {i_rx_data, dat[31:8]};
          cnt_d = cnt + 2'd1;
          if (cnt == 2'd3) begin
            if (dbg) begin
              state_d = ST_BUS;
              timer_d = '0;
            end else begin
              state_d   = ST_RESP;
              rsp_cnt_d = 3'd1;
              dat_d     = {24'h0, RSP_ERR};
            end
          end
        end
      end

      ST_BUS: begin
        if (i_wb_dbg_ack) begin
          state_d = ST_RESP;
          if (is_write) begin
            dat_d     = {24'h0, RSP_OK};
            rsp_cnt_d = 3'd1;
          end else begin
            dat_d     = i_wb_dbg_rdt;
            rsp_cnt_d = 3'd4;
          end
        end else if (timer == TIMER_LAST) begin
          state_d   = ST_RESP;
          rsp_cnt_d = 3'd1;
          dat_d     = {24'h0, RSP_ERR};
        end else begin
          timer_d = timer + TIMER_ONE;
        end
      end

      ST_RESP: begin
        if (tx_fire) begin
          dat_d     = {8'h00, dat[31:8]};
          rsp_cnt_d = rsp_cnt - 3'd1;
          if (rsp_cnt == 3'd1) state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, and every
    // register (shift registers included) is reset so all outputs read 0.
    if (i_rst) begin
      state    <= ST_IDLE;
      adr      <= '0;
      dat      <= '0;
      cnt      <= '0;
      rsp_cnt  <= '0;
      timer    <= '0;
      is_write <= 1'b0;
      dbg      <= 1'b0;
    end else begin
      state    <= state_d;
      adr      <= adr_d;
      dat      <= dat_d;
      cnt      <= cnt_d;
      rsp_cnt  <= rsp_cnt_d;
      timer    <= timer_d;
      is_write <= is_write_d;
      dbg      <= dbg_d;
    end
  end

endmodule
